ethernet_rx_frame_ctrl: RTL and testbench
=========================================

// Module: ethernet_rx_frame_ctrl
// PURPOSE
//  Frame-level sequencer between the MII nibble receiver and the RX byte FIFO.
//  - Hunts the preamble and SFD, packs nibbles into bytes and consumes the 6-byte destination MAC.
//  - Forwards the remaining bytes (source MAC onward) with end-of-frame and error marking.
//  - Drops runt frames and frames that overflow the FIFO.
// PARAMETERS
//  MIN_PREAMBLE  8            minimum count of 0x5 nibbles required before the SFD nibble
//  MAC_ADDR      48'h0200_0000_0001  station address, byte 0 in bits [47:40]
//  CNT_W         8            width of saturating frame counters
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  start        in   1      PHY init done; controller is idle while low
//  nibble_ready in   1      one-cycle strobe; nibble valid
//  nibble       in   4      MII data, low nibble of each byte first
//  frame_end    in   1      one-cycle pulse after the final nibble of a frame; never coincides with nibble_ready
//  out_full     in   1      downstream FIFO full
//  out_wr       out  1      FIFO write strobe
//  out_data     out  8      byte to FIFO
//  out_last     out  1      marks last word of frame (qualified by out_wr)
//  out_err      out  1      marks frame as bad (only with out_last)
//  frame_ok     out  1      one-cycle pulse: frame fully delivered
//  frame_drop   out  1      one-cycle pulse: frame discarded or truncated
//  ok_count     out  CNT_W  saturating count of frame_ok pulses
//  drop_count   out  CNT_W  saturating count of frame_drop pulses
//  busy         out  1      high in any state other than IDLE and HUNT
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state IDLE. start low for one cycle in any state -> IDLE next cycle.
//    No terminator is written and the held byte is lost.
//  IDLE:    start=1 -> HUNT.
//  HUNT:    0x5 nibble increments pcnt (saturates at 15).
//           0xD with pcnt>=MIN_PREAMBLE -> HEADER.
//           Any other nibble, or 0xD with pcnt short -> SKIP.
//           frame_end clears pcnt.
//  SKIP:    ignore nibbles until frame_end -> HUNT. No pulse, no count.
//  HEADER:  pack 6 bytes (lo|hi<<4). After byte 6 -> FORWARD.
//           frame_end here: frame_drop, -> HUNT.
//  FORWARD: one-byte hold register.
//           Each newly completed byte writes the previously held byte, with out_last=0, the cycle the new byte completes.
//           That write needs out_full=0. If out_full=1 -> DROP, frame_drop pulses, the held byte is lost.
//           frame_end with a held byte and no half nibble -> TERM with err=0.
//           frame_end with a dangling half nibble -> TERM with err=1.
//           frame_end with no held byte (empty payload) -> frame_drop, -> HUNT, no write.
//  DROP:    ignore nibbles until frame_end -> TERM with err=1, data 8'h00.
//  TERM:    wait while out_full=1.
//           When out_full=0: out_wr=1, out_last=1, out_err=err, data = held byte (or 0x00 in the DROP case).
//           frame_ok pulses if err=0. The frame_drop pulse for the DROP case was already given on overflow.
//           A dangling-nibble TERM pulses frame_drop instead. Then -> HUNT.
//           Nibbles arriving in TERM are ignored; their frame falls into SKIP via HUNT rules.
//  Outputs are registered; out_wr is at most 1 per cycle. Latency from nibble_ready completing byte n+1 to the write of byte n: 1 cycle.
//  Counters saturate at all-ones and never wrap.
// CONFIGURATION
//  ETHERNET_MAC_FILTER_EN defined:
//    At the end of HEADER, dest MAC must equal MAC_ADDR or 48'hFFFF_FFFF_FFFF.
//    Mismatch -> SKIP with frame_drop.
//  Not defined: every frame passing HEADER is accepted. The dest MAC is still consumed and not forwarded.
// STRUCTURE
//  Shared include ethernet_defs.vh holds:
//    state encodings, PREAMBLE_NIBBLE=4'h5, SFD_NIBBLE=4'hD, BROADCAST_MAC=48'hFFFF_FFFF_FFFF, HEADER_BYTES=6.
//  Sub-module ethernet_byte_packer (nibble to byte, half-nibble flag, clear input).
//  FSM, hold register and counters stay in this module.
// TESTING
//  1. 15x0x5, 0xD, dest=MAC_ADDR, payload A1 B2 C3, frame_end.
//     -> writes A1,B2,C3 with last on C3, err=0; frame_ok=1; ok_count=1.
//  2. Same frame with 0x5 count=7.
//     -> SKIP, no writes, no pulses, counters unchanged.
//  3. out_full=1 while byte 2 (B2) is due.
//     -> frame_drop, DROP.
//     -> after frame_end, single write data=00, last=1, err=1; drop_count=1.
//  4. frame_end after 3 header bytes -> frame_drop, no write.
//     Frame with an odd trailing nibble -> last held byte written with err=1.
//  5. With ETHERNET_MAC_FILTER_EN: dest=02:00:00:00:00:02 dropped; dest=FF:FF:FF:FF:FF:FF accepted.
//  6. reset mid-FORWARD, then a new valid frame -> no write before it; second frame delivered intact.

Source files
------------

// File: rtl/ethernet_rx_frame_ctrl_pkg.sv
// Shared types and constants for the Ethernet RX frame sequencer.
package ethernet_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StSkip,
    StHeader,
    StForward,
    StDrop,
    StTerm
  } state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [47:0] BROADCAST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned HEADER_BYTES    = 6;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ethernet_byte_packer.sv
// Packs MII nibbles (low nibble first) into bytes; exposes the dangling-half flag.
module ethernet_byte_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       nibble_ready,
  input  logic [3:0] nibble,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       half
);

  logic       half_q;
  logic [3:0] lo_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      half_q <= 1'b0;
      lo_q   <= 4'h0;
    end else if (nibble_ready) begin
      half_q <= ~half_q;
      if (!half_q) begin
        lo_q <= nibble;
      end
    end
  end

  assign byte_done = nibble_ready && half_q && !clear;
  assign byte_data = {nibble, lo_q};
  assign half      = half_q;

endmodule

// File: rtl/ethernet_rx_frame_ctrl.sv
// Frame sequencer between MII nibble receiver and RX byte FIFO.
// Optional destination filtering is enabled by defining ETHERNET_MAC_FILTER_EN.
module ethernet_rx_frame_ctrl
  import ethernet_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter logic [47:0] MAC_ADDR     = 48'h0200_0000_0001,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             nibble_ready,
  input  logic [3:0]       nibble,
  input  logic             frame_end,
  input  logic             out_full,
  output logic             out_wr,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             frame_ok,
  output logic             frame_drop,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

`ifdef ETHERNET_MAC_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [2:0]       hdr_cnt_q, hdr_cnt_d;
  logic [47:0]      dest_q, dest_d;
  logic [7:0]       held_q, held_d;
  logic             held_valid_q, held_valid_d;
  logic             term_err_q, term_err_d;
  logic             term_drop_q, term_drop_d;
  logic             out_wr_q, out_wr_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_err_q, out_err_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_drop_q, frame_drop_d;
  logic [CNT_W-1:0] ok_count_q, ok_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic       pk_clear;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       half;
  logic       mac_ok;

  assign pk_clear = !((state_q == StHeader) || (state_q == StForward));

  ethernet_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (pk_clear),
    .nibble_ready (nibble_ready),
    .nibble       (nibble),
    .byte_done    (byte_done),
    .byte_data    (byte_data),
    .half         (half)
  );

  // dest_d already holds all six bytes on the cycle the last header byte completes
  assign mac_ok = !FilterEn || (dest_d == MAC_ADDR) || (dest_d == BROADCAST_MAC);

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    dest_d       = dest_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    term_err_d   = term_err_q;
    term_drop_d  = term_drop_q;
    out_wr_d     = 1'b0;
    out_data_d   = 8'h00;
    out_last_d   = 1'b0;
    out_err_d    = 1'b0;
    frame_ok_d   = 1'b0;
    frame_drop_d = 1'b0;

    unique case (state_q)
      StIdle: state_d = StHunt;
      StHunt: begin
        if (frame_end) begin
          pcnt_d = 4'h0;
        end else if (nibble_ready) begin
          if (nibble == PREAMBLE_NIBBLE) begin
            pcnt_d = sat_inc4(pcnt_q);
          end else if ((nibble == SFD_NIBBLE) && (32'(pcnt_q) >= MIN_PREAMBLE)) begin
            state_d   = StHeader;
            pcnt_d    = 4'h0;
            hdr_cnt_d = 3'd0;
          end else begin
            state_d = StSkip;
            pcnt_d  = 4'h0;
          end
        end
      end
      StSkip: begin
        if (frame_end) state_d = StHunt;
      end
      StHeader: begin
        held_valid_d = 1'b0;
        if (frame_end) begin
          frame_drop_d = 1'b1;
          state_d      = StHunt;
        end else if (byte_done) begin
          dest_d    = {dest_q[39:0], byte_data};
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'(HEADER_BYTES - 1)) begin
            if (mac_ok) begin
              state_d = StForward;
            end else begin
              state_d      = StSkip;
              frame_drop_d = 1'b1;
            end
          end
        end
      end
      StForward: begin
        if (frame_end) begin
          if (!held_valid_q) begin
            frame_drop_d = 1'b1;
            state_d      = StHunt;
          end else begin
            term_err_d  = half;
            term_drop_d = half;
            state_d     = StTerm;
          end
        end else if (byte_done) begin
          if (held_valid_q && out_full) begin
            frame_drop_d = 1'b1;
            held_valid_d = 1'b0;
            state_d      = StDrop;
          end else begin
            out_wr_d     = held_valid_q;
            out_data_d   = held_valid_q ? held_q : 8'h00;
            held_d       = byte_data;
            held_valid_d = 1'b1;
          end
        end
      end
      StDrop: begin
        if (frame_end) begin
          held_d      = 8'h00;
          term_err_d  = 1'b1;
          term_drop_d = 1'b0;
          state_d     = StTerm;
        end
      end
      StTerm: begin
        if (!out_full) begin
          out_wr_d     = 1'b1;
          out_data_d   = held_q;
          out_last_d   = 1'b1;
          out_err_d    = term_err_q;
          frame_ok_d   = !term_err_q;
          frame_drop_d = term_drop_q;
          held_valid_d = 1'b0;
          state_d      = StHunt;
        end
      end
      default: state_d = StIdle;
    endcase

    // Losing start aborts whatever is in flight without a terminator
    if (!start) begin
      state_d      = StIdle;
      pcnt_d       = 4'h0;
      held_valid_d = 1'b0;
      out_wr_d     = 1'b0;
      out_data_d   = 8'h00;
      out_last_d   = 1'b0;
      out_err_d    = 1'b0;
      frame_ok_d   = 1'b0;
      frame_drop_d = 1'b0;
    end

    ok_count_d   = (frame_ok_d && (ok_count_q != '1)) ? ok_count_q + CNT_W'(1) : ok_count_q;
    drop_count_d = (frame_drop_d && (drop_count_q != '1)) ? drop_count_q + CNT_W'(1)
                                                          : drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pcnt_q       <= 4'h0;
      hdr_cnt_q    <= 3'd0;
      dest_q       <= 48'h0;
      held_q       <= 8'h00;
      held_valid_q <= 1'b0;
      term_err_q   <= 1'b0;
      term_drop_q  <= 1'b0;
      out_wr_q     <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_err_q    <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      ok_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      dest_q       <= dest_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      term_err_q   <= term_err_d;
      term_drop_q  <= term_drop_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_err_q    <= out_err_d;
      frame_ok_q   <= frame_ok_d;
      frame_drop_q <= frame_drop_d;
      ok_count_q   <= ok_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_wr     = out_wr_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_err    = out_err_q;
  assign frame_ok   = frame_ok_q;
  assign frame_drop = frame_drop_q;
  assign ok_count   = ok_count_q;
  assign drop_count = drop_count_q;
  assign busy       = (state_q != StIdle) && (state_q != StHunt);

endmodule

// File: tb/tb_ethernet_rx_frame_ctrl.sv
// Directed bench for ethernet_rx_frame_ctrl with a frame-level expectation model.
module tb_ethernet_rx_frame_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam logic [47:0] MAC   = 48'h0200_0000_0001;

  logic             clk = 1'b0;
  logic             reset, start, nibble_ready, frame_end, out_full;
  logic [3:0]       nibble;
  logic             out_wr, out_last, out_err, frame_ok, frame_drop, busy;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] ok_count, drop_count;

  always #5 clk = ~clk;

  ethernet_rx_frame_ctrl #(
    .MIN_PREAMBLE (8),
    .MAC_ADDR     (MAC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .nibble_ready (nibble_ready),
    .nibble       (nibble),
    .frame_end    (frame_end),
    .out_full     (out_full),
    .out_wr       (out_wr),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_err      (out_err),
    .frame_ok     (frame_ok),
    .frame_drop   (frame_drop),
    .ok_count     (ok_count),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;
  int ok_exp   = 0;
  int drop_exp = 0;
  logic [9:0] exp_wr[$];     // {data, last, err}
  logic [1:0] exp_pulse[$];  // {ok, drop}
  logic [7:0] fbytes[$];
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every DUT write and pulse must match the next model expectation in order
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr) begin
        last_data = out_data;
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h required=none", {out_data, out_last, out_err});
        end else begin
          check("write", {out_data, out_last, out_err}, exp_wr.pop_front());
        end
      end
      if (frame_ok || frame_drop) begin
        if (exp_pulse.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%0b required=none", {frame_ok, frame_drop});
        end else begin
          check("pulse", {frame_ok, frame_drop}, exp_pulse.pop_front());
        end
      end
    end
  end

  task automatic exp_ok();
    exp_pulse.push_back(2'b10);
    if (ok_exp < 255) ok_exp++;
  endtask

  task automatic exp_drop();
    exp_pulse.push_back(2'b01);
    if (drop_exp < 255) drop_exp++;
  endtask

  // Frame-level rules: preamble length, header length, dest filter, payload, overflow, odd nibble
  task automatic model_frame(input int npre, input bit odd, input int full_at);
    int n;
    int np;
    logic [47:0] dest;
    n = fbytes.size();
    if (((npre > 15) ? 15 : npre) < 8) return;
    if (n < 6) begin
      exp_drop();
      return;
    end
    dest = '0;
    for (int i = 0; i < 6; i++) dest = {dest[39:0], fbytes[i]};
`ifdef ETHERNET_MAC_FILTER_EN
    if (dest != MAC && dest != 48'hFFFF_FFFF_FFFF) begin
      exp_drop();
      return;
    end
`endif
    np = n - 6;
    if (np == 0) begin
      exp_drop();
      return;
    end
    if (full_at >= 1 && full_at < np) begin
      for (int i = 0; i < full_at - 1; i++) exp_wr.push_back({fbytes[6+i], 2'b00});
      exp_drop();
      exp_wr.push_back({8'h00, 2'b11});
      return;
    end
    for (int i = 0; i < np - 1; i++) exp_wr.push_back({fbytes[6+i], 2'b00});
    exp_wr.push_back({fbytes[n-1], 1'b1, odd});
    if (odd) exp_drop();
    else exp_ok();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, input bit full);
    nibble       = n;
    nibble_ready = 1'b1;
    out_full     = full;
    tick();
    nibble_ready = 1'b0;
    out_full     = 1'b0;
    tick();
  endtask

  task automatic send_body(input int npre, input bit odd, input int full_at);
    for (int i = 0; i < npre; i++) send_nib(4'h5, 1'b0);
    send_nib(4'hD, 1'b0);
    for (int i = 0; i < fbytes.size(); i++) begin
      send_nib(fbytes[i][3:0], 1'b0);
      send_nib(fbytes[i][7:4], (full_at >= 1) && (i - 6 == full_at));
    end
    if (odd) send_nib(4'h7, 1'b0);
  endtask

  task automatic end_and_settle(input int term_full);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    if (term_full > 0) begin
      out_full = 1'b1;
      for (int i = 0; i < term_full; i++) begin
        tick();
        check("term_hold_no_write", out_wr, 0);
      end
      out_full = 1'b0;
    end
    repeat (8) tick();
    check("writes_drained", exp_wr.size(), 0);
    check("pulses_drained", exp_pulse.size(), 0);
    check("ok_count", ok_count, ok_exp);
    check("drop_count", drop_count, drop_exp);
  endtask

  task automatic run_frame(input int npre, input bit odd, input int full_at, input int term_full);
    model_frame(npre, odd, full_at);
    send_body(npre, odd, full_at);
    end_and_settle(term_full);
  endtask

  task automatic build(input logic [47:0] dest, input int np, input logic [63:0] pl);
    fbytes.delete();
    for (int i = 0; i < 6; i++) fbytes.push_back(dest[8*(5-i) +: 8]);
    for (int i = 0; i < np; i++) fbytes.push_back(pl[8*(np-1-i) +: 8]);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b1;
    nibble_ready = 1'b0;
    nibble       = 4'h0;
    frame_end    = 1'b0;
    out_full     = 1'b0;
    repeat (3) tick();
    check("rst_out_wr", out_wr, 0);
    check("rst_pulses", {frame_ok, frame_drop}, 0);
    check("rst_counts", {ok_count, drop_count}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) tick();

    // 1: good frame
    build(MAC, 3, 64'hA1B2C3);
    run_frame(15, 1'b0, -1, 0);
    check("t1_last_byte", last_data, 8'hC3);
    check("t1_ok_count_lit", ok_count, 1);

    // 2: short preamble
    run_frame(7, 1'b0, -1, 0);
    check("t2_ok_count_lit", ok_count, 1);
    check("t2_drop_count_lit", drop_count, 0);

    // 3: overflow when B2 is due
    run_frame(15, 1'b0, 2, 0);
    check("t3_term_data", last_data, 8'h00);
    check("t3_drop_count_lit", drop_count, 1);

    // 4: truncated header, then odd trailing nibble
    build(MAC, 0, 64'h0);
    fbytes = fbytes[0:2];
    run_frame(15, 1'b0, -1, 0);
    build(MAC, 2, 64'h1122);
    run_frame(15, 1'b1, -1, 0);
    check("t4_odd_last", last_data, 8'h22);

    // Boundaries: exact minimum preamble, saturating preamble, empty payload, TERM backpressure
    build(MAC, 2, 64'h5A6B);
    run_frame(8, 1'b0, -1, 0);
    run_frame(20, 1'b0, -1, 0);
    build(MAC, 0, 64'h0);
    run_frame(10, 1'b0, -1, 0);
    build(MAC, 1, 64'h99);
    run_frame(9, 1'b0, -1, 3);
    check("term_hold_data", last_data, 8'h99);

    // 5: foreign and broadcast destinations
    build(48'h0200_0000_0002, 2, 64'h3344);
    run_frame(12, 1'b0, -1, 0);
    build(48'hFFFF_FFFF_FFFF, 2, 64'h7788);
    run_frame(12, 1'b0, -1, 0);
    check("t5_bcast_last", last_data, 8'h88);

    // start dropped mid-FORWARD: abort silently
    build(MAC, 1, 64'hEE);
    send_body(10, 1'b0, -1);
    check("fwd_busy", busy, 1);
    start = 1'b0;
    tick();
    check("start_low_busy", busy, 0);
    start = 1'b1;
    end_and_settle(0);

    // 6: reset mid-FORWARD then a fresh frame
    build(MAC, 1, 64'hDD);
    send_body(10, 1'b0, -1);
    reset = 1'b1;
    tick();
    tick();
    check("mid_rst_out_wr", out_wr, 0);
    check("mid_rst_counts", {ok_count, drop_count}, 0);
    ok_exp   = 0;
    drop_exp = 0;
    reset    = 1'b0;
    tick();
    build(MAC, 3, 64'hA1B2C3);
    run_frame(15, 1'b0, -1, 0);
    check("t6_last_byte", last_data, 8'hC3);
    check("t6_ok_count_lit", ok_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
